// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin timer arbiter.
// Holds the FSM state encoding, the default sizes and the round-robin pick function.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN} arb_state_t;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_NUM_CNT_BITS = 8;
  localparam int unsigned MAX_REQ          = 16;

  // First set bit strictly after ptr, wrapping modulo n; 0 when nothing is set.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         ptr,
                                         input int unsigned        n);
    logic [3:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= n; i++) begin
      idx = 4'((32'(ptr) + i) % n);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/timer_arbiter_counter.sv
// Clearable up-counter with programmable rollover value and registered rollover flag.
// The flag is high in the same cycle that count_out equals rollover_val.
module counter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_flag;
  logic [NUM_CNT_BITS-1:0] w_next;

  always_comb begin
    w_next = r_count + 1'b1;
    if (r_count == rollover_val) w_next = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (count_enable) begin
      r_count <= w_next;
      r_flag  <= (w_next == rollover_val);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one elapsed-time counter among NUM_REQ requesters.
// Grants the timer, sequences clear/count on the counter and pulses done at timeout.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            nRST,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] dur,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [ID_W-1:0]                 active_id,
  output logic [NUM_CNT_BITS-1:0]         elapsed
);

  arb_state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]         r_active_id;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [NUM_CNT_BITS-1:0] r_dur_q;

  logic [MAX_REQ-1:0]      w_req_ext;
  logic [ID_W-1:0]         w_pick;
  logic                    w_grab;
  logic                    w_clear;
  logic                    w_cnt_en;
  logic                    w_rollover;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [NUM_REQ-1:0]      w_done;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = req;
  end

  assign w_pick = ID_W'(rr_pick(w_req_ext, 4'(r_rr_ptr), NUM_REQ));

  always_comb begin
    w_state_nxt = r_state;
    w_grab      = 1'b0;
    w_clear     = 1'b0;
    w_cnt_en    = 1'b0;
    w_gnt       = '0;
    w_done      = '0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (|req) begin
          w_grab      = 1'b1;
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        w_gnt[r_active_id] = 1'b1;
        w_clear            = 1'b1;
        if (r_dur_q == '0) begin
          w_done[r_active_id] = 1'b1;
          w_state_nxt         = IDLE;
        end else if (!req[r_active_id]) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_gnt[r_active_id] = 1'b1;
        // Completion is checked before cancel so a same-cycle withdraw still sees done.
        if (w_rollover) begin
          w_done[r_active_id] = 1'b1;
          w_clear             = 1'b1;
          w_state_nxt         = IDLE;
        end else if (!req[r_active_id]) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_active_id <= '0;
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_dur_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grab) begin
        r_active_id <= w_pick;
        r_rr_ptr    <= w_pick;
        r_dur_q     <= dur[w_pick*NUM_CNT_BITS +: NUM_CNT_BITS];
      end
    end
  end

  counter #(
    .NUM_CNT_BITS(NUM_CNT_BITS)
  ) u_counter (
    .clk          (clk),
    .nRST         (nRST),
    .clear        (w_clear),
    .count_enable (w_cnt_en),
    .rollover_val (r_dur_q),
    .count_out    (elapsed),
    .rollover_flag(w_rollover)
  );

  assign gnt       = w_gnt;
  assign done      = w_done;
  assign busy      = (r_state != IDLE);
  assign active_id = (r_state == IDLE) ? '0 : r_active_id;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter (NUM_REQ=4, NUM_CNT_BITS=8).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_timer_arbiter;

  logic        clk;
  logic        nRST;
  logic [3:0]  req;
  logic [31:0] dur;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  active_id;
  logic [7:0]  elapsed;

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] dur;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  id;
    logic [7:0]  el;
  } vec_t;

  vec_t vecs [11];

  timer_arbiter #(
    .NUM_REQ     (4),
    .NUM_CNT_BITS(8)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .req      (req),
    .dur      (dur),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .active_id(active_id),
    .elapsed  (elapsed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".gnt"},  32'(gnt),       32'h0);
    chk({name, ".done"}, 32'(done),      32'h0);
    chk({name, ".busy"}, 32'(busy),      32'h0);
    chk({name, ".id"},   32'(active_id), 32'h0);
    chk({name, ".el"},   32'(elapsed),   32'h0);
  endtask

  // Leaves the bench on a falling edge with reset released and inputs idle.
  task automatic do_reset();
    nRST = 1'b0;
    req  = '0;
    dur  = '0;
    @(negedge clk);
    nRST = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_id;
    logic       early_done;
    logic       bad_trace;
    logic [3:0] done_257;
    logic [7:0] el_257;

    n_total = 0;
    n_pass  = 0;
    nRST = 1'b0;
    req  = '0;
    dur  = '0;
    #1;
    chk_idle("reset");
    @(negedge clk);
    nRST = 1'b1;

    // dur=3 on requester 0 (withdrawn in the completion cycle), then dur=0 on requester 1
    vecs[0]  = '{1'b1, 4'b0001, 32'h3, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0};
    vecs[1]  = '{1'b0, 4'b0001, 32'h3, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0};
    vecs[2]  = '{1'b0, 4'b0001, 32'h3, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0};
    vecs[3]  = '{1'b0, 4'b0001, 32'h3, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd1};
    vecs[4]  = '{1'b0, 4'b0001, 32'h3, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd2};
    vecs[5]  = '{1'b0, 4'b0000, 32'h3, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'd3};
    vecs[6]  = '{1'b0, 4'b0000, 32'h3, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0};
    vecs[7]  = '{1'b1, 4'b0010, 32'h0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0};
    vecs[8]  = '{1'b0, 4'b0010, 32'h0, 4'b0010, 4'b0010, 1'b1, 2'd1, 8'd0};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0};
    vecs[10] = '{1'b0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) do_reset();
      req = vecs[i].req;
      dur = vecs[i].dur;
      #1;
      chk($sformatf("vec%0d.gnt", i),  32'(gnt),       32'(vecs[i].gnt));
      chk($sformatf("vec%0d.done", i), 32'(done),      32'(vecs[i].done));
      chk($sformatf("vec%0d.busy", i), 32'(busy),      32'(vecs[i].busy));
      chk($sformatf("vec%0d.id", i),   32'(active_id), 32'(vecs[i].id));
      chk($sformatf("vec%0d.el", i),   32'(elapsed),   32'(vecs[i].el));
      @(negedge clk);
    end

    // Round robin: 0 and 2 both held, dur=2 each -> grants 0,2,0,2, five cycles apart
    do_reset();
    req = 4'b0101;
    dur = 32'h0002_0002;
    for (int g = 0; g < 4; g++) begin
      exp_id = (g % 2 == 0) ? 2'd0 : 2'd2;
      #1;
      chk($sformatf("rr%0d.idle_busy", g), 32'(busy), 32'h0);
      chk($sformatf("rr%0d.idle_gnt", g),  32'(gnt),  32'h0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d.arm_gnt", g),  32'(gnt),       32'(4'b0001 << exp_id));
      chk($sformatf("rr%0d.arm_id", g),   32'(active_id), 32'(exp_id));
      chk($sformatf("rr%0d.arm_done", g), 32'(done),      32'h0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d.el0", g), 32'(elapsed), 32'h0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d.el1", g),   32'(elapsed), 32'h1);
      chk($sformatf("rr%0d.done1", g), 32'(done),    32'h0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d.done", g), 32'(done),    32'(4'b0001 << exp_id));
      chk($sformatf("rr%0d.el2", g),  32'(elapsed), 32'h2);
      @(negedge clk);
    end
    req = '0;

    // Cancel: requester 3 with dur=10 withdraws at cycle 5; pending requester 0 goes next
    do_reset();
    req = 4'b1000;
    dur = 32'h0A00_0001;
    #1;
    chk("cxl.c0_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req = 4'b1001;
    #1;
    chk("cxl.c1_gnt", 32'(gnt),       32'h8);
    chk("cxl.c1_id",  32'(active_id), 32'h3);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("cxl.c%0d_el", c),   32'(elapsed), 32'(c - 2));
      chk($sformatf("cxl.c%0d_done", c), 32'(done),    32'h0);
    end
    @(negedge clk);
    req = 4'b0001;
    #1;
    chk("cxl.c5_gnt",  32'(gnt),     32'h8);
    chk("cxl.c5_done", 32'(done),    32'h0);
    chk("cxl.c5_el",   32'(elapsed), 32'h3);
    @(negedge clk); #1;
    chk_idle("cxl.c6");
    @(negedge clk); #1;
    chk("cxl.c7_gnt", 32'(gnt),       32'h1);
    chk("cxl.c7_id",  32'(active_id), 32'h0);
    @(negedge clk); #1;
    chk("cxl.c8_done", 32'(done), 32'h0);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("cxl.c9_done", 32'(done),    32'h1);
    chk("cxl.c9_el",   32'(elapsed), 32'h1);
    @(negedge clk); #1;
    chk("cxl.c10_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a dur=10 grant
    @(negedge clk);
    do_reset();
    req = 4'b0001;
    dur = 32'd10;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    #1;
    chk("mrst.c4_el",   32'(elapsed), 32'h2);
    chk("mrst.c4_busy", 32'(busy),    32'h1);
    nRST = 1'b0;
    #1;
    chk_idle("mrst.asserted");
    @(negedge clk);
    nRST = 1'b1;
    dur  = 32'd1;
    #1;
    chk("mrst.r0_busy", 32'(busy), 32'h0);
    @(negedge clk); #1;
    chk("mrst.r1_gnt",  32'(gnt),  32'h1);
    chk("mrst.r1_done", 32'(done), 32'h0);
    @(negedge clk); #1;
    chk("mrst.r2_done", 32'(done), 32'h0);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("mrst.r3_done", 32'(done),    32'h1);
    chk("mrst.r3_el",   32'(elapsed), 32'h1);
    @(negedge clk);

    // Maximum duration: done at cycle 257, elapsed tracks cycle-2 and never wraps
    do_reset();
    req        = 4'b0001;
    dur        = 32'hFF;
    early_done = 1'b0;
    bad_trace  = 1'b0;
    done_257   = '0;
    el_257     = '0;
    for (int c = 1; c <= 257; c++) begin
      @(negedge clk);
      if (c == 257) req = 4'b0000;
      #1;
      if (c < 257 && done != 4'b0000) early_done = 1'b1;
      if (c >= 2 && 32'(elapsed) != 32'(c - 2)) bad_trace = 1'b1;
      if (c == 257) begin
        done_257 = done;
        el_257   = elapsed;
      end
    end
    chk("max.early_done", 32'(early_done), 32'h0);
    chk("max.el_trace",   32'(bad_trace),  32'h0);
    chk("max.done_257",   32'(done_257),   32'h1);
    chk("max.el_257",     32'(el_257),     32'hFF);
    @(negedge clk); #1;
    chk_idle("max.after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one `counter` instance, used as a single elapsed-time timer, among NUM_REQ requesters.
- Each requester asks for a timeout of dur cycles. A round-robin arbiter grants the timer to one requester and sequences clear, count and rollover on the counter. It then pulses done to the winner.
- Sits between the pipeline units that need bounded waits (stall timeouts, backoff) and the shared counter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- NUM_CNT_BITS, 8, counter width and width of each duration field.
- ID_W, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request level; held until done or withdrawn.
- dur  in  NUM_REQ*NUM_CNT_BITS  packed durations; slice i belongs to requester i, sampled only at grant.
- gnt  out  NUM_REQ  one-hot grant, high while the owner holds the timer.
- done  out  NUM_REQ  one-hot, single-cycle timeout pulse to the owner.
- busy  out  1  timer owned (state != IDLE).
- active_id  out  ID_W  index of the current owner; 0 when idle.
- elapsed  out  NUM_CNT_BITS  counter count_out passthrough.

Behaviour:
- Reset values: gnt=0, done=0, busy=0, active_id=0, elapsed=0, state=IDLE, rr pointer=NUM_REQ-1 (so requester 0 wins first), dur_q=0.
- Counter drive:
  - rollover_val = dur_q (registered, stable for the whole grant).
  - clear and count_enable are decoded from state, as defined per state below.
- IDLE:
  - clear=1.
  - If any req is high, pick the first set bit searching from rr_ptr+1 with wrap-around.
  - Register active_id, dur_q = dur slice, rr_ptr = winner; go to ARM.
  - With no requests, stay in IDLE.
- ARM:
  - gnt[active_id]=1, clear=1.
  - If dur_q==0: done[active_id]=1 this cycle, go to IDLE.
  - Otherwise go to RUN.
- RUN:
  - gnt[active_id]=1, count_enable = !rollover_flag.
  - elapsed goes 1..dur_q on successive cycles.
  - The cycle in which rollover_flag==1 is the completion cycle: done[active_id]=1, count_enable=0, clear=1, next state IDLE.
- Latency: with req sampled in IDLE at cycle 0, done pulses at cycle dur+2; for dur=0 it pulses at cycle 1.
  - The next grant can start at cycle dur+3 (one IDLE cycle between grants).
- Cancel:
  - If req[active_id] drops in ARM, or in RUN without rollover_flag: clear=1, no done pulse, go to IDLE.
  - Completion beats cancel in the same cycle: done still pulses.
- req bits other than the owner's are ignored until IDLE. dur changes after the grant have no effect.
- Round-robin fairness: a requester holding req continuously is granted within NUM_REQ grants.
- Counter wrap-around cannot occur, because count_enable is gated off at rollover_flag.
- Maximum duration is 2^NUM_CNT_BITS-1.
- Reset mid-operation: everything returns to reset values asynchronously, including the counter. No done pulse is emitted.
- gnt and done are always one-hot or zero. done is never high outside ARM/RUN.

Decomposition:
- Package timer_arbiter_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARM, RUN} arb_state_t;
  - constants for default NUM_REQ and NUM_CNT_BITS.
- The single sub-module is `counter` (NUM_CNT_BITS passed through), instantiated once.
- Round-robin pick is a combinational function in the package (first set bit after pointer, with wrap); it is not a separate module.

Test Plan:
- req=4'b0001, dur[0]=3 at cycle 0 -> gnt=0001 in cycles 1..5, elapsed 1,2,3 in cycles 3,4,5, done[0] pulse at cycle 5, busy low at cycle 6.
- req=4'b0101 held, dur=2 for both -> grants in order 0, 2, 0, 2. Each done is a single pulse on the correct bit, with one IDLE cycle between grants.
- req=4'b0010, dur[1]=0 -> gnt[1] and done[1] both high at cycle 1 only; elapsed stays 0; IDLE at cycle 2.
- req[3] with dur=10, dropped at cycle 5 -> gnt drops at cycle 6, no done pulse, elapsed=0 at cycle 6; a pending req[0] is granted next.
- nRST asserted at cycle 4 of a dur=10 grant -> all outputs 0 immediately. After release, a new req[0] with dur=1 gives done at cycle 3 relative to its sampling.
- dur=8'hFF single request -> done exactly at cycle 257; elapsed never wraps to 0 before the done pulse.
